// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - round-robin arbiter sharing the apb bridge user port among NUM_REQ requesters
module apb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  input  logic [NUM_REQ-1:0]        wr_rd_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic                      trans_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic [DATA_W-1:0]         wdata_o,
  output logic                      wr_rd_o,
  input  logic                      pselx_i,
  input  logic                      penable_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  input  logic [DATA_W-1:0]         prdata_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               wr_rd_q, wr_rd_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W:0]     pos;
  logic               apb_done;

  // A transfer is finished when the bus shows an access phase with pready.
  assign apb_done = pselx_i & penable_i & pready_i;

  // Round-robin search: first requester at or after ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    pos    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr_q} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
        pos = pos - (IDX_W + 1)'(NUM_REQ);
      end
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = pos[IDX_W-1:0];
      end
    end
  end

  // Next-state logic: latch the winner in IDLE, pulse trans in ISSUE, capture the response in WAIT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_rd_d = wr_rd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = winner;
          gnt_d   = NUM_REQ'(1) << winner;
          addr_d  = addr_i[winner*ADDR_W +: ADDR_W];
          wdata_d = wdata_i[winner*DATA_W +: DATA_W];
          wr_rd_d = wr_rd_i[winner];
          ptr_d   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (apb_done) begin
          // Writes return zero data so a requester never sees stale bus contents.
          rdata_d = wr_rd_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_rd_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_rd_q <= wr_rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = (state_q == DONE) ? (NUM_REQ'(1) << idx_q) : '0;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q != IDLE);
  assign trans_o = (state_q == ISSUE);
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign wr_rd_o = wr_rd_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - self-checking bench for apb_arbiter with an APB slave model and round-robin reference
module tb_apb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic [N-1:0]  req_i;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [N-1:0]  wr_rd_i;
  logic [N-1:0]  gnt_o, done_o;
  logic [DW-1:0] rdata_o;
  logic          err_o, busy_o, trans_o, wr_rd_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          pselx_i, penable_i, pready_i, pslverr_i;
  logic [DW-1:0] prdata_i;

  apb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk(pclk), .preset_n(preset_n), .req_i(req_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wr_rd_i(wr_rd_i), .gnt_o(gnt_o), .done_o(done_o),
    .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o), .trans_o(trans_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .wr_rd_o(wr_rd_o),
    .pselx_i(pselx_i), .penable_i(penable_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .prdata_i(prdata_i)
  );

  always #5 pclk = ~pclk;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  // Requester side: remaining transfer count and the request payload.
  int            cnt [N];
  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_wdata [N];
  logic          a_wr [N];

  // Slave knobs: fixed response, or one derived from the address.
  bit            slave_auto = 1'b0;
  int            slave_ws   = 0;
  logic [DW-1:0] slave_rdata = '0;
  logic          slave_err  = 1'b0;
  int            cur_ws;
  logic [DW-1:0] cur_rd;
  logic          cur_er;

  function automatic logic [DW-1:0] f_rdata(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction
  function automatic logic f_err(input logic [AW-1:0] a);
    return a[12];
  endfunction
  function automatic int f_ws(input logic [AW-1:0] a);
    return int'(a[9:8]);
  endfunction

  // APB slave behind the bridge: setup one cycle after trans, then access with wait states.
  initial begin
    pselx_i = 0; penable_i = 0; pready_i = 0; pslverr_i = 0; prdata_i = '0;
    forever begin
      @(negedge pclk);
      if (preset_n && trans_o) begin
        cur_ws = slave_auto ? f_ws(addr_o)    : slave_ws;
        cur_rd = slave_auto ? f_rdata(addr_o) : slave_rdata;
        cur_er = slave_auto ? f_err(addr_o)   : slave_err;
        @(negedge pclk);
        pselx_i = 1; penable_i = 0; pready_i = 0; pslverr_i = 0; prdata_i = $urandom;
        @(negedge pclk);
        penable_i = 1;
        for (int w = 0; w < cur_ws; w++) begin
          pready_i = 0; prdata_i = $urandom;
          @(negedge pclk);
        end
        pready_i = 1; prdata_i = cur_rd; pslverr_i = cur_er;
        @(negedge pclk);
        pselx_i = 0; penable_i = 0; pready_i = 0; pslverr_i = 0; prdata_i = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_i[k]             = (cnt[k] > 0);
      wr_rd_i[k]           = a_wr[k];
      addr_i[k*AW +: AW]   = a_addr[k];
      wdata_i[k*DW +: DW]  = a_wdata[k];
    end
  endtask

  // One clock: sample just after the falling edge, retire finished requests, redrive.
  task automatic step();
    @(negedge pclk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (done_o[k] && cnt[k] > 0) cnt[k]--;
    end
    drive();
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    int w;
    w = -1;
    for (int i = 0; i < N; i++) if (w < 0 && r[(p + i) % N]) w = (p + i) % N;
    return w;
  endfunction

  function automatic bit all_idle();
    bit z;
    z = 1'b1;
    for (int k = 0; k < N; k++) if (cnt[k] != 0) z = 1'b0;
    return z && !busy_o;
  endfunction

  // Observation record of one run.
  int            o_ntrans, o_ndone, o_gnt_bad, o_addr_bad, o_pready_cyc, o_done_cyc;
  bit            o_timeout;
  logic [N-1:0]  o_done_val, o_gnt_or;
  logic [DW-1:0] o_rdata, o_wdata;
  logic          o_err;
  logic [AW-1:0] o_addr;
  int            o_gnt_seq [$];
  int            o_gnt_cyc [$];
  int            o_done_cycs [$];

  task automatic observe(input int drop_k, input int pulse_k, input int max_steps);
    logic [N-1:0]  g_prev;
    logic [AW-1:0] a_hold;
    bit fin;
    o_ntrans = 0; o_ndone = 0; o_gnt_bad = 0; o_addr_bad = 0; o_pready_cyc = -100;
    o_done_cyc = 0; o_timeout = 1'b0; o_done_val = '0; o_gnt_or = '0; o_rdata = '0;
    o_wdata = '0; o_err = 1'b0; o_addr = '0; a_hold = '0;
    o_gnt_seq.delete(); o_gnt_cyc.delete(); o_done_cycs.delete();
    g_prev = gnt_o;
    fin = 1'b0;
    for (int s = 0; s < max_steps && !fin; s++) begin
      step();
      if (trans_o) o_ntrans++;
      if (gnt_o != '0 && g_prev == '0) begin
        o_gnt_seq.push_back(oh_idx(gnt_o));
        o_gnt_cyc.push_back(cyc);
        a_hold = addr_o;
        o_addr = addr_o;
      end else if (gnt_o != '0 && gnt_o != g_prev) begin
        o_gnt_bad++;
      end
      if (busy_o && gnt_o == '0) o_gnt_bad++;
      if (gnt_o != '0 && addr_o !== a_hold) o_addr_bad++;
      o_gnt_or |= gnt_o;
      if (pselx_i && penable_i && pready_i) o_pready_cyc = cyc;
      if (done_o != '0) begin
        o_ndone++; o_done_val = done_o; o_rdata = rdata_o; o_err = err_o;
        o_wdata = wdata_o; o_done_cyc = cyc; o_done_cycs.push_back(cyc);
      end
      if (drop_k >= 0 && pselx_i) cnt[drop_k] = 0;
      if (pulse_k >= 0) cnt[pulse_k] = pselx_i ? 1 : 0;
      drive();
      g_prev = gnt_o;
      if (all_idle()) fin = 1'b1;
    end
    o_timeout = !fin;
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    drive();
    step(); step();
    preset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0; a_addr[k] = '0; a_wdata[k] = '0; a_wr[k] = 1'b0;
    end
    drive();
    step(); step();
    total++;
    if ({gnt_o, done_o, busy_o, trans_o} !== '0) $display("FAIL reset_ctrl: got gnt=%b done=%b busy=%b trans=%b required all 0", gnt_o, done_o, busy_o, trans_o);
    else pass_cnt++;
    total++;
    if ({rdata_o, err_o, addr_o, wdata_o, wr_rd_o} !== '0) $display("FAIL reset_data: got rdata=%h err=%b addr=%h wdata=%h wr=%b required all 0", rdata_o, err_o, addr_o, wdata_o, wr_rd_o);
    else pass_cnt++;
    preset_n = 1'b1;
    step();
    total++;
    if (busy_o !== 1'b0) $display("FAIL reset_idle: busy got %b required 0", busy_o);
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    slave_auto = 1'b0; slave_ws = 0; slave_rdata = 32'hDEAD_BEEF; slave_err = 1'b0;
    a_addr[2] = 32'h10; a_wr[2] = 1'b0; a_wdata[2] = 32'h0; cnt[2] = 1;
    drive();
    observe(-1, -1, 60);
    total++;
    if (o_timeout || o_ndone != 1 || o_done_val !== 4'b0100) $display("FAIL single_done: got done=%b count=%0d timeout=%0d required 0100 once", o_done_val, o_ndone, o_timeout);
    else pass_cnt++;
    total++;
    if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) $display("FAIL single_rdata: got rdata=%h err=%b required deadbeef err 0", o_rdata, o_err);
    else pass_cnt++;
    total++;
    if (o_gnt_seq.size() != 1 || o_gnt_seq[0] != 2 || o_gnt_bad != 0 || o_addr !== 32'h10 || o_addr_bad != 0) $display("FAIL single_gnt: got grants=%0d gnt_bad=%0d addr=%h addr_bad=%0d required one grant to 2, addr 10", o_gnt_seq.size(), o_gnt_bad, o_addr, o_addr_bad);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    slave_auto = 1'b1;
    for (int k = 0; k < N; k++) begin
      a_addr[k] = 32'h100 * (k + 1); a_wdata[k] = 32'hA0 + k; a_wr[k] = 1'b0; cnt[k] = 1;
    end
    cnt[0] = 2;
    drive();
    observe(-1, -1, 200);
    total++;
    if (o_timeout || o_gnt_seq.size() != 5 || o_gnt_seq[0] != 0 || o_gnt_seq[1] != 1 ||
        o_gnt_seq[2] != 2 || o_gnt_seq[3] != 3 || o_gnt_seq[4] != 0)
      $display("FAIL rr_order: got %0d grants timeout=%0d required order 0,1,2,3,0", o_gnt_seq.size(), o_timeout);
    else pass_cnt++;
    total++;
    if (o_ntrans != 5 || o_ndone != 5) $display("FAIL rr_counts: got trans=%0d done=%0d required 5 and 5", o_ntrans, o_ndone);
    else pass_cnt++;
    for (int i = 1; i < 5; i++) begin
      total++;
      if (o_gnt_cyc.size() < 5 || o_done_cycs.size() < 4) $display("FAIL rr_gap%0d: got too few events required 5 grants", i);
      else if (o_gnt_cyc[i] - o_done_cycs[i-1] != 2) $display("FAIL rr_gap%0d: got done-to-grant %0d cycles required 2", i, o_gnt_cyc[i] - o_done_cycs[i-1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_err();
    slave_auto = 1'b0; slave_ws = 0; slave_rdata = 32'hFFFF_FFFF; slave_err = 1'b1;
    a_addr[1] = 32'h20; a_wdata[1] = 32'h55; a_wr[1] = 1'b1; cnt[1] = 1;
    drive();
    observe(-1, -1, 60);
    total++;
    if (o_timeout || o_done_val !== 4'b0010 || o_err !== 1'b1) $display("FAIL wr_err: got done=%b err=%b required 0010 err 1", o_done_val, o_err);
    else pass_cnt++;
    total++;
    if (o_rdata !== '0 || o_wdata !== 32'h55) $display("FAIL wr_data: got rdata=%h wdata=%h required 0 and 55", o_rdata, o_wdata);
    else pass_cnt++;
    a_wr[1] = 1'b0;
  endtask

  task automatic test_wait_states();
    slave_auto = 1'b0; slave_ws = 3; slave_rdata = 32'h1234_ABCD; slave_err = 1'b0;
    a_addr[0] = 32'h44; a_wr[0] = 1'b0; cnt[0] = 1;
    drive();
    observe(-1, -1, 60);
    total++;
    if (o_timeout || o_gnt_bad != 0 || o_addr_bad != 0) $display("FAIL ws_stable: got gnt_bad=%0d addr_bad=%0d timeout=%0d required 0", o_gnt_bad, o_addr_bad, o_timeout);
    else pass_cnt++;
    total++;
    if (o_ntrans != 1) $display("FAIL ws_trans: got %0d trans cycles required 1", o_ntrans);
    else pass_cnt++;
    total++;
    if (o_done_cyc - o_pready_cyc != 1 || o_ndone != 1) $display("FAIL ws_done: got pready-to-done %0d cycles, %0d pulses required 1 and 1", o_done_cyc - o_pready_cyc, o_ndone);
    else pass_cnt++;
    total++;
    if (o_rdata !== 32'h1234_ABCD) $display("FAIL ws_rdata: got %h required 1234abcd", o_rdata);
    else pass_cnt++;
  endtask

  task automatic test_req_drop();
    slave_auto = 1'b0; slave_ws = 1; slave_rdata = 32'h0BAD_F00D; slave_err = 1'b0;
    a_addr[3] = 32'h30; a_wr[3] = 1'b0; cnt[3] = 1;
    drive();
    observe(3, -1, 60);
    total++;
    if (o_timeout || o_ndone != 1 || o_done_val !== 4'b1000 || o_gnt_seq.size() != 1) $display("FAIL drop_done: got done=%b count=%0d grants=%0d required 1000 once", o_done_val, o_ndone, o_gnt_seq.size());
    else pass_cnt++;
    slave_ws = 2;
    a_addr[0] = 32'h50; a_wr[0] = 1'b0; cnt[0] = 1;
    drive();
    observe(-1, 2, 60);
    total++;
    if (o_timeout || o_gnt_or[2] !== 1'b0 || o_ndone != 1) $display("FAIL withdraw: got gnt_seen=%b done count=%0d required no grant to 2", o_gnt_or, o_ndone);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    bit hit;
    slave_auto = 1'b0; slave_ws = 3; slave_rdata = 32'h7777_1111; slave_err = 1'b0;
    a_addr[2] = 32'hABC0; a_wdata[2] = 32'h99; a_wr[2] = 1'b0; cnt[2] = 1;
    drive();
    hit = 1'b0;
    for (int s = 0; s < 20 && !hit; s++) begin
      step();
      if (pselx_i && penable_i) hit = 1'b1;
    end
    total++;
    if (!hit) $display("FAIL rst_reach_wait: got no access phase within 20 cycles required one");
    else pass_cnt++;
    preset_n = 1'b0;
    #1;
    total++;
    if ({gnt_o, done_o, rdata_o, err_o, busy_o, trans_o, addr_o, wdata_o, wr_rd_o} !== '0)
      $display("FAIL rst_async: got gnt=%b done=%b busy=%b trans=%b addr=%h rdata=%h required all 0", gnt_o, done_o, busy_o, trans_o, addr_o, rdata_o);
    else pass_cnt++;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    drive();
    for (int s = 0; s < 8; s++) step();
    slave_ws = 0;
    a_addr[1] = 32'h111; a_wr[1] = 1'b0; cnt[1] = 1;
    a_addr[3] = 32'h333; a_wr[3] = 1'b0; cnt[3] = 1;
    drive();
    preset_n = 1'b1;
    observe(-1, -1, 80);
    total++;
    if (o_timeout || o_gnt_seq.size() != 2 || o_gnt_seq[0] != 1 || o_gnt_seq[1] != 3) $display("FAIL rst_first_gnt: got %0d grants, first=%0d required 1 then 3", o_gnt_seq.size(), (o_gnt_seq.size() > 0) ? o_gnt_seq[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int mptr, w, exp_w;
    logic [N-1:0] rp, exp_oh;
    bit fin;
    do_reset();
    slave_auto = 1'b1;
    mptr = 0; exp_w = 0;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < N; k++) begin
        cnt[k] = $urandom_range(0, 2);
        a_addr[k] = $urandom; a_wdata[k] = $urandom; a_wr[k] = 1'($urandom_range(0, 1));
      end
      drive();
      fin = 1'b0;
      for (int s = 0; s < 400 && !fin; s++) begin
        rp = req_i;
        step();
        if (trans_o) begin
          w = rr_pick(rp, mptr);
          exp_oh = '0;
          if (w >= 0) exp_oh[w] = 1'b1;
          total++;
          if (w < 0 || gnt_o !== exp_oh) $display("FAIL rand_gnt: round %0d got gnt=%b required %b", r, gnt_o, exp_oh);
          else pass_cnt++;
          if (w >= 0) begin
            total++;
            if (addr_o !== a_addr[w] || wdata_o !== a_wdata[w] || wr_rd_o !== a_wr[w])
              $display("FAIL rand_latch: got addr=%h wdata=%h wr=%b required %h %h %b", addr_o, wdata_o, wr_rd_o, a_addr[w], a_wdata[w], a_wr[w]);
            else pass_cnt++;
            mptr = (w + 1) % N;
            exp_w = w;
          end
        end
        if (done_o != '0) begin
          exp_oh = '0;
          exp_oh[exp_w] = 1'b1;
          total++;
          if (done_o !== exp_oh) $display("FAIL rand_done: got %b required %b", done_o, exp_oh);
          else pass_cnt++;
          total++;
          if (rdata_o !== (a_wr[exp_w] ? '0 : f_rdata(a_addr[exp_w])) || err_o !== f_err(a_addr[exp_w]))
            $display("FAIL rand_resp: got rdata=%h err=%b required %h %b", rdata_o, err_o, a_wr[exp_w] ? '0 : f_rdata(a_addr[exp_w]), f_err(a_addr[exp_w]));
          else pass_cnt++;
        end
        if (all_idle()) fin = 1'b1;
      end
      total++;
      if (!fin) $display("FAIL rand_timeout: round %0d did not drain", r);
      else pass_cnt++;
    end
  endtask

  initial begin
    req_i = '0; addr_i = '0; wdata_i = '0; wr_rd_i = '0; preset_n = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_err();
    test_wait_states();
    test_req_drop();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
